// File: rtl/spi_ram_controller.sv
// SPI master for an external SPI RAM: one-word READ (03h) / WRITE (02h) frames, mode 0, MSB first.
// Optional build macro SPI_RAM_SIZE_EN enables 1/2/4-byte transfers via the size input.
module spi_ram_controller #(
  parameter int DIV    = 1,
  parameter int CS_GAP = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        is_write,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        spi_select,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on any clk edge where start=1 and busy=0; while busy=1
  // start is ignored, and done pulses once per accepted request before busy drops.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  logic [1:0]  state_q, state_d;
  logic [63:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [6:0]  bits_q, bits_d;
  logic [15:0] tick_q, tick_d;
  logic [1:0]  len_q, len_d;
  logic        wr_q, wr_d;
  logic        sel_q, sel_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  start_len;
  logic [6:0]  start_bits;
  logic [31:0] rx_next;
  logic [31:0] rd_word;

`ifdef SPI_RAM_SIZE_EN
  always_comb begin
    case (size)
      2'd0:    start_len = 2'd0;
      2'd1:    start_len = 2'd1;
      default: start_len = 2'd2;
    endcase
  end
`else
  logic size_unused;
  assign size_unused = ^size;
  assign start_len   = 2'd2;
`endif

  always_comb begin
    case (start_len)
      2'd0:    start_bits = 7'd40;
      2'd1:    start_bits = 7'd48;
      default: start_bits = 7'd64;
    endcase
  end

  // The first received data byte is the oldest of the last 8n sampled bits; it maps to rdata[7:0].
  always_comb begin
    rx_next = {rx_q[30:0], spi_miso};
    case (len_q)
      2'd0:    rd_word = {24'h0, rx_next[7:0]};
      2'd1:    rd_word = {16'h0, rx_next[7:0], rx_next[15:8]};
      default: rd_word = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bits_d  = bits_q;
    tick_d  = tick_q;
    len_d   = len_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          tx_d    = {(is_write ? 8'h02 : 8'h03), addr,
                     wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
          bits_d  = start_bits;
          tick_d  = 16'd0;
          len_d   = start_len;
          wr_d    = is_write;
          sel_d   = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = tx_d[63];
        end
      end
      ST_SHIFT: begin
        if (tick_q == DIV_LAST) begin
          tick_d = 16'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: MISO was driven on the previous fall, so it is stable here.
            sclk_d = 1'b0;
            rx_d   = rx_next;
            tx_d   = {tx_q[62:0], 1'b0};
            mosi_d = tx_d[63];
            bits_d = bits_q - 7'd1;
            if (bits_q == 7'd1) begin
              state_d = ST_GAP;
              sel_d   = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
              if (!wr_q) rdata_d = rd_word;
            end
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (tick_q == GAP_LAST) state_d = ST_IDLE;
        else                    tick_d  = tick_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tx_q    <= 64'h0;
      rx_q    <= 32'h0;
      bits_q  <= 7'd0;
      tick_q  <= 16'd0;
      len_q   <= 2'd2;
      wr_q    <= 1'b0;
      sel_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bits_q  <= bits_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign spi_select = sel_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_ram_controller.sv
// Bench for spi_ram_controller: two instances (DIV=1/CS_GAP=2 and DIV=2/CS_GAP=4) share one
// behavioural SPI RAM device; a byte-level memory model predicts frames and read data.
module tb_spi_ram_controller;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        is_write = 1'b0;
  logic [23:0] addr = 24'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  size = 2'd2;
  logic        spi_miso = 1'b0;
  bit          use2 = 1'b0;

  logic        busy1, done1, sel1, sclk1, mosi1;
  logic [31:0] rdata1;
  logic [1:0]  st1;
  logic        busy2, done2, sel2, sclk2, mosi2;
  logic [31:0] rdata2;
  logic [1:0]  st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_controller #(.DIV(1), .CS_GAP(2)) dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .is_write(is_write), .addr(addr),
    .wdata(wdata), .size(size), .busy(busy1), .done(done1), .rdata(rdata1),
    .spi_select(sel1), .spi_clk(sclk1), .spi_mosi(mosi1), .spi_miso(spi_miso),
    .dbg_state(st1)
  );

  spi_ram_controller #(.DIV(2), .CS_GAP(4)) dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .is_write(is_write), .addr(addr),
    .wdata(wdata), .size(size), .busy(busy2), .done(done2), .rdata(rdata2),
    .spi_select(sel2), .spi_clk(sclk2), .spi_mosi(mosi2), .spi_miso(spi_miso),
    .dbg_state(st2)
  );

  logic        m_sel, m_sclk, m_mosi, m_busy, m_done;
  logic [31:0] m_rdata;
  assign m_sel   = use2 ? sel2   : sel1;
  assign m_sclk  = use2 ? sclk2  : sclk1;
  assign m_mosi  = use2 ? mosi2  : mosi1;
  assign m_busy  = use2 ? busy2  : busy1;
  assign m_done  = use2 ? done2  : done1;
  assign m_rdata = use2 ? rdata2 : rdata1;

  // ---------------- SPI RAM device (mode 0) ----------------
  logic [7:0]  dev_mem [logic [23:0]];
  bit          mosi_bits[$];
  int          ram_bit_n = 0;
  logic [7:0]  ram_cmd = 8'h0;
  logic [7:0]  ram_byte = 8'h0;
  logic [23:0] ram_addr = 24'h0;

  function automatic logic [7:0] dev_rd(input logic [23:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
  endfunction

  always @(posedge m_sclk) begin
    if (!m_sel) begin
      mosi_bits.push_back(m_mosi);
      ram_bit_n++;
      if (ram_bit_n <= 8) ram_cmd = {ram_cmd[6:0], m_mosi};
      else if (ram_bit_n <= 32) ram_addr = {ram_addr[22:0], m_mosi};
      else if (ram_cmd == 8'h02) begin
        ram_byte = {ram_byte[6:0], m_mosi};
        if ((ram_bit_n - 32) % 8 == 0)
          dev_mem[ram_addr + 24'((ram_bit_n - 33) / 8)] = ram_byte;
      end
    end
  end

  always @(negedge m_sclk) begin
    if (!m_sel) begin
      if (ram_bit_n >= 32 && ram_cmd == 8'h03) begin
        int j;
        logic [7:0] b;
        j = ram_bit_n - 32;
        b = dev_rd(ram_addr + 24'(j / 8));
        spi_miso = b[7 - (j % 8)];
      end else begin
        spi_miso = 1'($urandom);
      end
    end
  end

  always @(posedge m_sel) ram_bit_n = 0;

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [23:0]];
  logic [7:0] exp_q[$];

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

`ifdef SPI_RAM_SIZE_EN
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction
`else
  function automatic int nbytes(input logic [1:0] sz_unused);
    return 4;
  endfunction
`endif

  // One full request on the selected instance; poke>0 pulses start again at that cycle.
  task automatic do_txn(input bit d2, input bit w, input logic [23:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input int poke, output logic [31:0] rd_obs);
    int n, nbits, cyc, hi, rises, gap_c, dones, div, csg;
    bit seen, prev;
    logic [31:0] exp_rd;
    logic [7:0] got_b;
    div = d2 ? 2 : 1;
    csg = d2 ? 4 : 2;
    n = nbytes(sz);
    nbits = 32 + 8 * n;
    exp_q.delete();
    exp_q.push_back(w ? 8'h02 : 8'h03);
    exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_rd = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (w) exp_q.push_back(wd[8*k +: 8]);
      else   exp_rd[8*k +: 8] = ref_rd(a + 24'(k));
    end
    use2 = d2;
    mosi_bits.delete();
    rd_obs = 32'h0;
    @(negedge clk);
    is_write = w; addr = a; wdata = wd; size = sz;
    if (d2) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start2 = 1'b0;
    cyc = 0; seen = 0; dones = 0; hi = 0; rises = 0; prev = 0;
    while (!seen && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_sclk && !prev) rises++;
      if (m_sclk) hi++;
      prev = m_sclk;
      if (poke != 0 && cyc == poke) begin
        addr = ~a; is_write = ~w;
        if (d2) start2 = 1'b1; else start1 = 1'b1;
      end
      if (poke != 0 && cyc == poke + 1) begin
        start1 = 1'b0; start2 = 1'b0; addr = a; is_write = w;
      end
      if (m_done) begin seen = 1; dones++; rd_obs = m_rdata; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: done not seen after %0d cycles, required within %0d", cyc, 1 + nbits*2*div);
    end
    n_checks++;
    if (cyc + 1 != 1 + nbits*2*div) begin
      n_fail++;
      $display("FAIL done_latency: done at T+%0d, required T+%0d", cyc + 1, 1 + nbits*2*div);
    end
    n_checks++;
    if (rises != nbits || hi != nbits*div) begin
      n_fail++;
      $display("FAIL spi_clk_shape: %0d rises/%0d high cycles, required %0d/%0d", rises, hi, nbits, nbits*div);
    end
    n_checks++;
    if (m_sel !== 1'b1 || m_busy !== 1'b1 || m_mosi !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle: sel=%b busy=%b mosi=%b, required sel=1 busy=1 mosi=0", m_sel, m_busy, m_mosi);
    end
    if (!w) begin
      n_checks++;
      if (rd_obs !== exp_rd) begin
        n_fail++;
        $display("FAIL rdata @%06h: got %08h, required %08h", a, rd_obs, exp_rd);
      end
    end
    n_checks++;
    if (mosi_bits.size() != nbits) begin
      n_fail++;
      $display("FAIL frame_len: %0d bits, required %0d", mosi_bits.size(), nbits);
    end
    if (mosi_bits.size() >= 8 * exp_q.size()) begin
      for (int b = 0; b < exp_q.size(); b++) begin
        got_b = 8'h0;
        for (int i = 0; i < 8; i++) got_b = {got_b[6:0], mosi_bits[b*8 + i]};
        n_checks++;
        if (got_b !== exp_q[b]) begin
          n_fail++;
          $display("FAIL mosi_byte%0d: got %02h, required %02h", b, got_b, exp_q[b]);
        end
      end
    end
    if (w) for (int k = 0; k < n; k++) ref_mem[a + 24'(k)] = wd[8*k +: 8];
    gap_c = 0;
    while (m_busy && gap_c < 100) begin
      @(posedge clk);
      #1;
      gap_c++;
      if (m_done) dones++;
      if (m_busy && !m_sel) begin
        n_checks++; n_fail++;
        $display("FAIL gap_select: select low during gap cycle %0d, required high", gap_c);
      end
    end
    n_checks++;
    if (gap_c != csg || dones != 1) begin
      n_fail++;
      $display("FAIL gap_busy: busy low after %0d cycles with %0d dones, required %0d and 1", gap_c, dones, csg);
    end
  endtask

  task automatic test_reset;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({sel1, sclk1, mosi1, busy1, done1} !== 5'b10000 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: sel/clk/mosi/busy/done=%b rdata=%08h, required 10000 and 0",
               {sel1, sclk1, mosi1, busy1, done1}, rdata1);
    end
    n_checks++;
    if ({sel2, sclk2, mosi2, busy2, done2} !== 5'b10000 || rdata2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dut2: sel/clk/mosi/busy/done=%b rdata=%08h, required 10000 and 0",
               {sel2, sclk2, mosi2, busy2, done2}, rdata2);
    end
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    do_txn(0, 1, 24'h000010, 32'hDEADBEEF, 2'd2, 0, rd);
    do_txn(0, 0, 24'h000010, 32'h0, 2'd2, 0, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_back_0x10: got %08h, required deadbeef", rd);
    end
    do_txn(0, 0, 24'h800000, 32'h0, 2'd2, 0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL read_unwritten: got %08h, required 00000000", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    do_txn(0, 1, 24'h000030, $urandom, 2'd2, 40, rd);
    do_txn(0, 0, 24'h000030, 32'h0, 2'd2, 0, rd);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int cyc;
    use2 = 0;
    mosi_bits.delete();
    @(negedge clk);
    is_write = 1'b1; addr = 24'h000020; wdata = $urandom; size = 2'd2; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (mosi_bits.size() < 20 && cyc < 500) begin @(posedge clk); cyc++; end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (sel1 !== 1'b1 || sclk1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || mosi1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: sel=%b clk=%b busy=%b done=%b mosi=%b, required 1 0 0 0 0",
               sel1, sclk1, busy1, done1, mosi1);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    do_txn(0, 0, 24'h000010, 32'h0, 2'd2, 0, rd);
    do_txn(0, 0, 24'h000020, 32'h0, 2'd2, 0, rd);
  endtask

  task automatic test_div2;
    logic [31:0] rd;
    do_txn(1, 0, 24'h000010, 32'h0, 2'd2, 0, rd);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL div2_read: got %08h, required deadbeef", rd);
    end
    do_txn(1, 1, 24'h000040, $urandom, 2'd2, 0, rd);
    do_txn(1, 0, 24'h000040, 32'h0, 2'd2, 0, rd);
  endtask

`ifdef SPI_RAM_SIZE_EN
  task automatic test_size;
    logic [31:0] rd;
    do_txn(0, 1, 24'h000011, 32'h00000055, 2'd0, 0, rd);
    do_txn(0, 0, 24'h000010, 32'h0, 2'd2, 0, rd);
    n_checks++;
    if (rd !== 32'hDEAD55EF) begin
      n_fail++;
      $display("FAIL size_word_read: got %08h, required dead55ef", rd);
    end
    do_txn(0, 0, 24'h000010, 32'h0, 2'd1, 0, rd);
    n_checks++;
    if (rd !== 32'h000055EF) begin
      n_fail++;
      $display("FAIL size_half_read: got %08h, required 000055ef", rd);
    end
  endtask
`endif

  task automatic test_random;
    logic [31:0] rd;
    logic [23:0] a;
    for (int i = 0; i < 14; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'h000100 + 24'($urandom_range(0, 31));
      do_txn(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), a, $urandom,
             2'($urandom_range(0, 3)), 0, rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    test_div2();
`ifdef SPI_RAM_SIZE_EN
    test_size();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
